// File: rtl/uart_rx32.sv
// uart_rx32: 8N1 deframer packing four LSB-first bytes into a 32-bit word
// ports: clk, reset (sync, active-high), rx (async serial, idle high),
//        dato (last full word), listo (word-valid pulse), err_frame (bad stop pulse),
//        busy (frame in progress or partial word held)
module uart_rx32 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] dato,
  output logic        listo,
  output logic        err_frame,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW = $clog2(TO + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic [23:0] word;
  logic [1:0] byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic brk;
  logic mid, full, tout;
  assign rx_s = sync[1];
  assign mid  = clk_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign full = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign tout = state == IDLE && byte_cnt != 2'd0 && idle_cnt == IW'(TO - 1);
  assign busy = state != IDLE || byte_cnt != 2'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!rx_s && !brk) ? START : IDLE;
      START:   state_n = mid ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = (full && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = full ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      brk       <= 1'b0;
      dato      <= '0;
      listo     <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_n;
      listo     <= 1'b0;
      err_frame <= 1'b0;
      clk_cnt   <= (state == IDLE || (state == START && mid) || full) ? '0 : clk_cnt + 1'b1;
      idle_cnt  <= (state == IDLE && byte_cnt != 2'd0 && !tout) ? idle_cnt + 1'b1 : '0;
      if (state == START) bit_idx <= '0;
      if (state == DATA && full) begin
        sh      <= {rx_s, sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (rx_s) brk <= 1'b0;
      if (tout) byte_cnt <= '0;
      // a low stop bit arms the break latch so a held-low line yields a single error
      if (state == STOP && full) begin
        if (rx_s) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) begin
            dato  <= {sh, word};
            listo <= 1'b1;
          end else begin
            word[{byte_cnt, 3'b000} +: 8] <= sh;
          end
        end else begin
          err_frame <= 1'b1;
          byte_cnt  <= '0;
          brk       <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx32.sv
// tb_uart_rx32: randomized scoreboard bench for uart_rx32 with a byte-level reference model
module tb_uart_rx32;
  localparam int N = 8;
  localparam int T = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic [31:0] dato;
  logic listo, err_frame, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0] part[$];
  int listo_t[$];
  logic [31:0] prev_dato = '0;
  logic rst_d = 1'b1;
  uart_rx32 #(.CLKS_PER_BIT(N), .TIMEOUT_BITS(T)) dut (
    .clk(clk), .reset(reset), .rx(rx), .dato(dato),
    .listo(listo), .err_frame(err_frame), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (listo) begin
      listo_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_listo: dato %h with no word expected", dato);
      end else chk("word", dato, exp_q.pop_front());
    end
    if (err_frame) err_seen++;
    if (listo && err_frame) begin
      errors++;
      $display("FAIL overlap: listo and err_frame both high");
    end
    if (!listo && !reset && !rst_d && dato !== prev_dato) begin
      errors++;
      $display("FAIL dato_hold: dato changed %h -> %h without listo", prev_dato, dato);
    end
    prev_dato = dato;
    rst_d = reset;
  end
  task automatic bitt(input logic v);
    rx = v;
    repeat (N) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] b, input bit good);
    if (good) begin
      part.push_back(b);
      if (part.size() == 4) begin
        exp_q.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end else begin
      part.delete();
      exp_err++;
    end
    bitt(1'b0);
    for (int i = 0; i < 8; i++) bitt(b[i]);
    bitt(good);
  endtask
  task automatic idle(input int c);
    rx = 1'b1;
    if (c >= T * N) part.delete();
    repeat (c) @(posedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    part.delete();
    repeat (2) @(posedge clk);
    reset = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b1);
  endtask
  task automatic settle(input string name);
    idle(2 * N);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_errs"}, err_seen, exp_err);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    bit g;
    int r;
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dato", dato, 0);
    chk("rst_listo", listo, 0);
    chk("rst_err", err_frame, 0);
    chk("rst_busy", busy, 0);
    send_word(32'hDEADBEEF);
    settle("t1");
    rx = 1'b0;
    repeat (2) @(posedge clk);
    idle(20);
    @(negedge clk);
    chk("t2_busy", busy, 0);
    settle("t2");
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    idle(2 * N);
    send_word(32'h04030201);
    settle("t3");
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    @(negedge clk);
    chk("t4_busy_partial", busy, 1);
    idle(40);
    @(negedge clk);
    chk("t4_busy_timeout", busy, 0);
    send_word(32'h0D0C0B0A);
    settle("t4");
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b1);
    bitt(1'b0);
    for (int i = 0; i < 5; i++) bitt(1'b1 ^ i[0]);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("t5_dato_rst", dato, 0);
    chk("t5_busy_rst", busy, 0);
    idle(6 * N);
    chk("t5_no_spurious", exp_q.size(), 0);
    send_word(32'h12345678);
    settle("t5");
    listo_t.delete();
    send_word(32'hCAFEF00D);
    send_word(32'h89ABCDEF);
    settle("t6");
    chk("t6_listo_count", listo_t.size(), 2);
    if (listo_t.size() == 2) chk("t6_listo_gap", listo_t[1] - listo_t[0], 40 * N);
    send(8'h77, 1'b1);
    exp_err++;
    part.delete();
    rx = 1'b0;
    repeat (15 * N) @(posedge clk);
    idle(3 * N);
    @(negedge clk);
    chk("t7_busy_break", busy, 0);
    chk("t7_one_err", err_seen, exp_err);
    send_word(32'h0BADCAFE);
    settle("t7");
    for (int k = 0; k < 32; k++) begin
      b = 8'($urandom);
      g = $urandom_range(0, 7) != 0;
      send(b, g);
      r = $urandom_range(0, 3);
      if (!g) idle($urandom_range(N, 16));
      else if (r == 1) idle($urandom_range(1, 16));
      else if (r == 3) idle($urandom_range(40, 80));
    end
    idle(6 * N);
    settle("rand");
    chk("rand_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
